vc_pop_arbiter: RTL and testbench

//  Read-side controller for the VC0/VC1 virtual-channel FIFOs. Decides each cycle which VC (if any) to pop.

---
 rtl/vc_pop_arbiter.sv | 121 ++++++++++++
 tb/tb_vc_pop_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_pop_arbiter.sv
// Read-side pop controller for the VC0/VC1 FIFOs: VC0 priority, pause stall, per-VC pop counters.
// Optional VC1 anti-starvation burst limit is enabled by defining VC1_ANTISTARVE_EN.
module vc_pop_arbiter #(
    parameter int BURST_MAX = 4,
    parameter int BURST_W   = 3,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             VC0_empty,
    input  logic             VC1_empty,
    input  logic             D0_pause,
    input  logic             D1_pause,
    output logic             VC0_rd,
    output logic             VC1_rd,
    output logic             vc0_delay,
    output logic             idle_out,
    output logic [CNT_W-1:0] vc0_pop_cnt,
    output logic [CNT_W-1:0] vc1_pop_cnt
);

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_PAUSE  = 2'd3;

    if (BURST_MAX >= (1 << BURST_W)) begin : g_burst_w_check
        $error("vc_pop_arbiter: BURST_W cannot hold BURST_MAX");
    end

    logic [1:0]       state_q, state_d;
    logic             idle_q, idle_d;
    logic [CNT_W-1:0] vc0_cnt_q, vc0_cnt_d;
    logic [CNT_W-1:0] vc1_cnt_q, vc1_cnt_d;
    logic             pause, any_data, pop_ok;
    logic             starve_force, grant1;
    logic             vc0_rd_w, vc1_rd_w;

    assign pause    = D0_pause | D1_pause;
    assign any_data = ~VC0_empty | ~VC1_empty;
    assign pop_ok   = (state_q == ST_ACTIVE) & ~pause;

    // VC1 wins only when VC0 has nothing, or when VC0 has used up its burst allowance.
    assign grant1   = VC0_empty | starve_force;
    assign vc0_rd_w = pop_ok & ~VC0_empty & ~grant1;
    assign vc1_rd_w = pop_ok & ~VC1_empty & grant1;

`ifdef VC1_ANTISTARVE_EN
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

    assign starve_force = (burst_cnt_q == BURST_W'(BURST_MAX)) & ~VC1_empty;

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (vc1_rd_w || VC1_empty) begin
            burst_cnt_d = '0;
        end else if (vc0_rd_w && (burst_cnt_q != BURST_W'(BURST_MAX))) begin
            burst_cnt_d = burst_cnt_q + BURST_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    assign starve_force = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:   state_d = ST_IDLE;
            ST_IDLE: begin
                if (pause)         state_d = ST_PAUSE;
                else if (any_data) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (pause)          state_d = ST_PAUSE;
                else if (!any_data) state_d = ST_IDLE;
            end
            ST_PAUSE: begin
                if (!pause) state_d = any_data ? ST_ACTIVE : ST_IDLE;
            end
            default:   state_d = ST_INIT;
        endcase
    end

    always_comb begin
        idle_d    = (state_d == ST_IDLE);
        vc0_cnt_d = vc0_cnt_q;
        vc1_cnt_d = vc1_cnt_q;
        if (vc0_rd_w) vc0_cnt_d = vc0_cnt_q + CNT_W'(1);
        if (vc1_rd_w) vc1_cnt_d = vc1_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= ST_INIT;
            idle_q    <= 1'b0;
            vc0_cnt_q <= '0;
            vc1_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idle_q    <= idle_d;
            vc0_cnt_q <= vc0_cnt_d;
            vc1_cnt_q <= vc1_cnt_d;
        end
    end

    assign VC0_rd      = vc0_rd_w;
    assign VC1_rd      = vc1_rd_w;
    assign vc0_delay   = vc1_rd_w;
    assign idle_out    = idle_q;
    assign vc0_pop_cnt = vc0_cnt_q;
    assign vc1_pop_cnt = vc1_cnt_q;

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Randomized and directed bench for vc_pop_arbiter against a FIFO-occupancy reference model.
module tb_vc_pop_arbiter;

    localparam int BMAX    = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MOD = 1 << CNT_W;

    localparam int M_INIT   = 0;
    localparam int M_IDLE   = 1;
    localparam int M_ACTIVE = 2;
    localparam int M_PAUSE  = 3;

    logic             clk = 1'b0;
    logic             reset_L = 1'b0;
    logic             VC0_empty = 1'b1;
    logic             VC1_empty = 1'b1;
    logic             D0_pause = 1'b0;
    logic             D1_pause = 1'b0;
    logic             VC0_rd, VC1_rd, vc0_delay, idle_out;
    logic [CNT_W-1:0] vc0_pop_cnt, vc1_pop_cnt;

    vc_pop_arbiter #(.BURST_MAX(BMAX), .BURST_W(3), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_L(reset_L),
        .VC0_empty(VC0_empty), .VC1_empty(VC1_empty),
        .D0_pause(D0_pause), .D1_pause(D1_pause),
        .VC0_rd(VC0_rd), .VC1_rd(VC1_rd), .vc0_delay(vc0_delay), .idle_out(idle_out),
        .vc0_pop_cnt(vc0_pop_cnt), .vc1_pop_cnt(vc1_pop_cnt)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int miss = 0;

    // Bench-side FIFOs: word counts; the empty flags follow them.
    int q0 = 0, q1 = 0;
    int pops0 = 0, pops1 = 0;
    int pop_log[$];
    logic last_rd0, last_rd1, last_idle;

    // Reference model: controller mode, VC0 pops in a row while VC1 waits, pop totals.
    int m_st = M_INIT;
    int m_streak = 0;
    int mc0 = 0, mc1 = 0;

    task automatic set_flags();
        VC0_empty = (q0 == 0);
        VC1_empty = (q1 == 0);
    endtask

    task automatic add(input int n0, input int n1);
        q0 += n0;
        q1 += n1;
        set_flags();
    endtask

    task automatic model_reset();
        m_st = M_INIT;
        m_streak = 0;
        mc0 = 0;
        mc1 = 0;
    endtask

    // One clock: check the DUT against the model mid-cycle, then advance both at the edge.
    task automatic cycle();
        bit pz, f, has0, has1, e0, e1;
        @(negedge clk);
        pz   = D0_pause | D1_pause;
        has0 = (q0 > 0);
        has1 = (q1 > 0);
        f    = 1'b0;
`ifdef VC1_ANTISTARVE_EN
        f    = (m_streak >= BMAX) && has1;
`endif
        e0 = (m_st == M_ACTIVE) && !pz && has0 && !f;
        e1 = (m_st == M_ACTIVE) && !pz && has1 && !e0;
        vec++; if (VC0_rd !== e0) begin miss++; $display("FAIL VC0_rd got=%b exp=%b t=%0t", VC0_rd, e0, $time); end
        vec++; if (VC1_rd !== e1) begin miss++; $display("FAIL VC1_rd got=%b exp=%b t=%0t", VC1_rd, e1, $time); end
        vec++; if (vc0_delay !== e1) begin miss++; $display("FAIL vc0_delay got=%b exp=%b t=%0t", vc0_delay, e1, $time); end
        vec++; if (idle_out !== (m_st == M_IDLE)) begin miss++; $display("FAIL idle_out got=%b exp=%b t=%0t", idle_out, (m_st == M_IDLE), $time); end
        vec++; if (vc0_pop_cnt !== CNT_W'(mc0)) begin miss++; $display("FAIL vc0_pop_cnt got=%0d exp=%0d t=%0t", vc0_pop_cnt, mc0, $time); end
        vec++; if (vc1_pop_cnt !== CNT_W'(mc1)) begin miss++; $display("FAIL vc1_pop_cnt got=%0d exp=%0d t=%0t", vc1_pop_cnt, mc1, $time); end
        last_rd0  = VC0_rd;
        last_rd1  = VC1_rd;
        last_idle = idle_out;
        if (VC0_rd === 1'b1) pop_log.push_back(0);
        if (VC1_rd === 1'b1) pop_log.push_back(1);
        @(posedge clk);
        #1;
        mc0 = (mc0 + int'(e0)) % CNT_MOD;
        mc1 = (mc1 + int'(e1)) % CNT_MOD;
        if (e1 || !has1) m_streak = 0;
        else if (e0)     m_streak++;
        case (m_st)
            M_INIT:   m_st = M_IDLE;
            M_IDLE:   m_st = pz ? M_PAUSE : ((has0 || has1) ? M_ACTIVE : M_IDLE);
            M_ACTIVE: m_st = pz ? M_PAUSE : ((has0 || has1) ? M_ACTIVE : M_IDLE);
            default:  m_st = pz ? M_PAUSE : ((has0 || has1) ? M_ACTIVE : M_IDLE);
        endcase
        if (last_rd0 === 1'b1) begin pops0++; if (q0 > 0) q0--; end
        if (last_rd1 === 1'b1) begin pops1++; if (q1 > 0) q1--; end
        set_flags();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        D0_pause = 1'b0;
        D1_pause = 1'b0;
        while (!(q0 == 0 && q1 == 0 && m_st == M_IDLE) && n < budget) begin
            cycle();
            n++;
        end
        vec++;
        if (n >= budget) begin miss++; $display("FAIL drain_timeout got=%0d exp<%0d", n, budget); end
    endtask

    // Holds reset three cycles with the given FIFO contents; strobes and counters must stay clear.
    task automatic apply_reset(input int n0, input int n1);
        reset_L  = 1'b0;
        D0_pause = 1'b0;
        D1_pause = 1'b0;
        q0 = n0;
        q1 = n1;
        set_flags();
        repeat (3) begin
            @(negedge clk);
            vec++; if ({VC0_rd, VC1_rd, vc0_delay} !== 3'b000) begin miss++; $display("FAIL reset_strobes got=%b exp=000", {VC0_rd, VC1_rd, vc0_delay}); end
            vec++; if (idle_out !== 1'b0) begin miss++; $display("FAIL reset_idle got=%b exp=0", idle_out); end
            vec++; if ({vc0_pop_cnt, vc1_pop_cnt} !== '0) begin miss++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", vc0_pop_cnt, vc1_pop_cnt); end
            @(posedge clk);
            #1;
        end
        reset_L = 1'b1;
        model_reset();
    endtask

    task automatic to_idle();
        apply_reset(0, 0);
        cycle();
        cycle();
        pop_log.delete();
    endtask

    task automatic test_reset();
        apply_reset(2, 1);
        cycle();
        vec++; if ({last_rd0, last_idle} !== 2'b00) begin miss++; $display("FAIL init_cycle got=%b exp=00", {last_rd0, last_idle}); end
        cycle();
        vec++; if ({last_rd0, last_idle} !== 2'b01) begin miss++; $display("FAIL idle_cycle got=%b exp=01", {last_rd0, last_idle}); end
        cycle();
        vec++; if (last_rd0 !== 1'b1) begin miss++; $display("FAIL first_pop got=%b exp=1", last_rd0); end
        drain(50);
    endtask

    task automatic test_vc0_only();
        logic [5:0] seen;
        to_idle();
        add(3, 0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            seen[5-i] = last_rd0;
            vec++; if (last_rd1 !== 1'b0) begin miss++; $display("FAIL vc0_only_delay got=%b exp=0", last_rd1); end
        end
        vec++; if (seen !== 6'b011100) begin miss++; $display("FAIL vc0_only_pattern got=%b exp=011100", seen); end
        vec++; if (last_idle !== 1'b1) begin miss++; $display("FAIL vc0_only_idle got=%b exp=1", last_idle); end
        vec++; if (vc0_pop_cnt !== 8'd3) begin miss++; $display("FAIL vc0_only_cnt got=%0d exp=3", vc0_pop_cnt); end
    endtask

    task automatic test_priority_order();
        int exp_order[$];
        to_idle();
`ifdef VC1_ANTISTARVE_EN
        exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
        add(10, 2);
`else
        exp_order = '{0, 0, 0, 0, 0, 0, 1, 1};
        add(6, 2);
`endif
        drain(40);
        vec++;
        if (pop_log.size() != exp_order.size()) begin
            miss++; $display("FAIL order_len got=%0d exp=%0d", pop_log.size(), exp_order.size());
        end else begin
            for (int i = 0; i < exp_order.size(); i++) begin
                vec++; if (pop_log[i] != exp_order[i]) begin miss++; $display("FAIL order[%0d] got=%0d exp=%0d", i, pop_log[i], exp_order[i]); end
            end
        end
    endtask

    task automatic test_pause();
        to_idle();
        add(8, 0);
        repeat (4) cycle();
        D1_pause = 1'b1;
        cycle();
        vec++; if (last_rd0 !== 1'b0) begin miss++; $display("FAIL pause_same_cycle got=%b exp=0", last_rd0); end
        cycle();
        vec++; if (last_rd0 !== 1'b0) begin miss++; $display("FAIL pause_hold got=%b exp=0", last_rd0); end
        D1_pause = 1'b0;
        cycle();
        vec++; if (last_rd0 !== 1'b0) begin miss++; $display("FAIL pause_release got=%b exp=0", last_rd0); end
        cycle();
        vec++; if (last_rd0 !== 1'b1) begin miss++; $display("FAIL pause_resume got=%b exp=1", last_rd0); end
        drain(40);
        vec++; if (vc0_pop_cnt !== 8'd8) begin miss++; $display("FAIL pause_total got=%0d exp=8", vc0_pop_cnt); end
    endtask

    task automatic test_reset_mid_burst_and_wrap();
        int start, n;
        to_idle();
        add(300, 0);
        start = pops0;
        n = 0;
        while (pops0 - start < 200 && n < 400) begin cycle(); n++; end
        vec++; if (pops0 - start != 200) begin miss++; $display("FAIL burst_reach got=%0d exp=200", pops0 - start); end
        vec++; if (VC0_rd !== 1'b1) begin miss++; $display("FAIL burst_live got=%b exp=1", VC0_rd); end
        reset_L = 1'b0;
        #1;
        vec++; if (VC0_rd !== 1'b0) begin miss++; $display("FAIL async_rd got=%b exp=0", VC0_rd); end
        vec++; if (vc0_pop_cnt !== 8'd0) begin miss++; $display("FAIL async_cnt got=%0d exp=0", vc0_pop_cnt); end
        to_idle();
        add(300, 0);
        start = pops0;
        n = 0;
        while (pops0 - start < 256 && n < 400) begin cycle(); n++; end
        vec++; if (vc0_pop_cnt !== 8'd0) begin miss++; $display("FAIL wrap_zero got=%0d exp=0", vc0_pop_cnt); end
        drain(200);
        vec++; if (vc0_pop_cnt !== 8'd44) begin miss++; $display("FAIL wrap_final got=%0d exp=44", vc0_pop_cnt); end
    endtask

    task automatic test_random();
        to_idle();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) add($urandom_range(0, 3), $urandom_range(0, 3));
            D0_pause = ($urandom_range(0, 9) == 0);
            D1_pause = ($urandom_range(0, 9) == 0);
            cycle();
        end
        drain(200);
        vec++; if (vc0_pop_cnt + vc1_pop_cnt !== CNT_W'(mc0 + mc1)) begin miss++; $display("FAIL random_total got=%0d exp=%0d", vc0_pop_cnt + vc1_pop_cnt, CNT_W'(mc0 + mc1)); end
    endtask

    initial begin
        test_reset();
        test_vc0_only();
        test_priority_order();
        test_pause();
        test_reset_mid_burst_and_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
